// File: rtl/pong_pkg.sv
// Shared Pong constants: VGA raster geometry, scheduler state encoding and
// the frame counter width. The VGA timing block imports the same geometry.
package pong_pkg;

    localparam int H_TOTAL     = 800;  // pixel clocks per line
    localparam int V_VISIBLE   = 480;  // visible lines
    localparam int V_TOTAL     = 525;  // lines per frame
    localparam int RASTER_W    = 10;   // width of xpix / ypix
    localparam int FRAME_CNT_W = 16;   // width of the committed-frame counter

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GO     = 2'd1,
        ST_WAIT   = 2'd2,
        ST_COMMIT = 2'd3
    } sched_state_t;

endpackage

// File: rtl/pong_frame_scheduler_if.sv
// Bundle between the frame scheduler, the VGA timing block and the game tasks.
//
// Handshake: the scheduler raises task_go[i] for exactly one cycle to start
// task i; the task answers with a one-cycle task_done[i] pulse at any later
// cycle. Only the done bit of the task currently being waited on is honoured;
// done bits of other tasks, or a done in the go cycle itself, are ignored.
// commit and overrun are single-cycle, mutually exclusive status pulses.
interface pong_frame_scheduler_if
    import pong_pkg::*;
#(
    parameter int N_TASKS = 3
);
    logic [RASTER_W-1:0]    xpix;
    logic [RASTER_W-1:0]    ypix;
    logic                   pause;
    logic [N_TASKS-1:0]     task_done;
    logic [N_TASKS-1:0]     task_go;
    logic                   busy;
    logic                   commit;
    logic                   overrun;
    logic [FRAME_CNT_W-1:0] frame_cnt;

    // Scheduler side.
    modport master (
        input  xpix, ypix, pause, task_done,
        output task_go, busy, commit, overrun, frame_cnt
    );

    // Raster source, task logic and state-buffer side.
    modport slave (
        output xpix, ypix, pause, task_done,
        input  task_go, busy, commit, overrun, frame_cnt
    );
endinterface

// File: rtl/pong_timeout_ctr.sv
// Per-task watchdog: cleared when a task is started, counts while the
// scheduler waits, and flags the TIMEOUT-th waiting cycle without a done.
module pong_timeout_ctr #(
    parameter int  TIMEOUT = 1023,
    localparam int W       = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [W-1:0] cnt;

    // Count enabled cycles since the last clear; hold once the limit is reached.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable && (cnt != TIMEOUT[W-1:0])) begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt holds the number of waiting cycles already elapsed, so the current
    // cycle is the TIMEOUT-th one when cnt equals TIMEOUT-1.
    always_comb begin
        expired = enable && (cnt == W'(TIMEOUT - 1));
    end

endmodule

// File: rtl/pong_frame_scheduler.sv
// Once-per-frame update sequencer for Pong. At the last pixel of the visible
// area it starts the game tasks in index order through go/done handshakes,
// then issues a one-cycle commit that swaps the game-state double buffer.
// A task timeout, or the vertical blank running out, aborts with overrun.
module pong_frame_scheduler
    import pong_pkg::*;
#(
    parameter int N_TASKS = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    pong_frame_scheduler_if.master bus,
    output sched_state_t           state_dbg
);

    localparam int              IDX_W    = (N_TASKS > 1) ? $clog2(N_TASKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TASKS - 1);

    sched_state_t       state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_TASKS-1:0] go_d;
    logic               abort_d;
    logic               tick, vend;
    logic               done_sel;
    logic               ctr_clear, ctr_en, expired;

    // Raster events: end of the last visible line, and end of the frame.
    always_comb begin
        tick = (bus.xpix == RASTER_W'(H_TOTAL - 1)) && (bus.ypix == RASTER_W'(V_VISIBLE - 1));
        vend = (bus.xpix == RASTER_W'(H_TOTAL - 1)) && (bus.ypix == RASTER_W'(V_TOTAL - 1));
    end

    // Only the completion of the task currently being waited on matters.
    always_comb begin
        done_sel = bus.task_done[idx_q];
    end

    // Watchdog is cleared while issuing go and runs while waiting for done.
    always_comb begin
        ctr_clear = (state_q == ST_GO);
        ctr_en    = (state_q == ST_WAIT);
    end

    pong_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (ctr_clear),
        .enable  (ctr_en),
        .expired (expired)
    );

    // Next-state logic: vend beats done, done beats timeout.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        abort_d = 1'b0;
        go_d    = '0;
        case (state_q)
            ST_IDLE: begin
                if (tick && !bus.pause) begin
                    state_d = ST_GO;
                    idx_d   = '0;
                end
            end
            ST_GO: begin
                if (vend) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (vend) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end else if (done_sel) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_COMMIT;
                    end else begin
                        state_d = ST_GO;
                        idx_d   = idx_q + 1'b1;
                    end
                end else if (expired) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d == ST_GO) begin
            go_d = N_TASKS'(1) << idx_d;
        end
    end

    // State and registered outputs; outputs are decoded from the next state
    // so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            bus.task_go   <= '0;
            bus.busy      <= 1'b0;
            bus.commit    <= 1'b0;
            bus.overrun   <= 1'b0;
            bus.frame_cnt <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            bus.task_go <= go_d;
            bus.busy    <= (state_d != ST_IDLE);
            bus.commit  <= (state_d == ST_COMMIT);
            bus.overrun <= abort_d;
            if (state_d == ST_COMMIT) begin
                bus.frame_cnt <= bus.frame_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_pong_frame_scheduler.sv
// Bench for pong_frame_scheduler: drives the raster directly (seeking to the
// frame tick and blank end), answers go pulses with done pulses, and checks
// every go/commit/overrun pulse against an expected-event queue.
module tb_pong_frame_scheduler;
    import pong_pkg::*;

    localparam int N       = 3;
    localparam int TIMEOUT = 1023;
    localparam int EW      = 50;   // {cycle[31:0], kind[1:0], data[15:0]}

    localparam logic [1:0] K_GO  = 2'd1;
    localparam logic [1:0] K_CMT = 2'd2;
    localparam logic [1:0] K_OVR = 2'd3;

    logic         clk = 1'b0;
    logic         rst;
    sched_state_t state_dbg;

    pong_frame_scheduler_if #(.N_TASKS(N)) bus ();

    pong_frame_scheduler #(
        .N_TASKS (N),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bench state ----------------
    int            cyc;
    int            n_checks;
    int            n_errors;
    int            reply_dly [N];   // cycles from go to done; -1 = never reply
    int            done_at   [N];
    bit            go_seen   [N];
    bit            expect_timeout;
    bit            sched_active;
    logic [15:0]   model_fc;
    logic [EW-1:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [EW-1:0] mk_evt(input int c, input logic [1:0] k, input logic [15:0] d);
        return {32'(c), k, d};
    endfunction

    task automatic cancel_dones();
        for (int i = 0; i < N; i++) done_at[i] = -1;
    endtask

    // Advance the reference model for an expected event that has now occurred.
    task automatic handle_evt(input logic [EW-1:0] e);
        int          ec;
        int          i;
        logic [1:0]  k;
        ec = int'(e[49:18]);
        k  = e[17:16];
        if (k == K_GO) begin
            i = int'(e[15:0]);
            go_seen[i] = 1'b1;
            if (reply_dly[i] >= 1) begin
                done_at[i] = ec + reply_dly[i];
                if (i < N - 1) exp_q.push_back(mk_evt(done_at[i] + 1, K_GO, 16'(i + 1)));
                else           exp_q.push_back(mk_evt(done_at[i] + 1, K_CMT, model_fc + 16'd1));
            end else if (expect_timeout) begin
                exp_q.push_back(mk_evt(ec + TIMEOUT + 1, K_OVR, model_fc));
            end
        end else if (k == K_CMT) begin
            model_fc     = model_fc + 16'd1;
            sched_active = 1'b0;
        end else begin
            sched_active = 1'b0;
        end
    endtask

    // Inputs for the current cycle are final: predict the DUT's reaction.
    task automatic evaluate_inputs();
        bit tick_in, vend_in;
        tick_in = (bus.xpix == 10'(H_TOTAL - 1)) && (bus.ypix == 10'(V_VISIBLE - 1));
        vend_in = (bus.xpix == 10'(H_TOTAL - 1)) && (bus.ypix == 10'(V_TOTAL - 1));
        if (!rst) begin
            if (tick_in && !bus.pause && !sched_active) begin
                sched_active = 1'b1;
                exp_q.push_back(mk_evt(cyc + 1, K_GO, 16'd0));
            end
            if (vend_in && sched_active) begin
                exp_q.delete();
                cancel_dones();
                exp_q.push_back(mk_evt(cyc + 1, K_OVR, model_fc));
            end
        end
    endtask

    // Compare DUT pulses of this cycle with the head of the expected queue.
    task automatic monitor();
        logic [EW-1:0] act, e;
        logic [1:0]    k;
        logic [15:0]   d;
        int            gi;
        while (exp_q.size() != 0 && int'(exp_q[0][49:18]) < cyc) begin
            e = exp_q.pop_front();
            check("missed_evt", 64'd0, 64'(e));
            handle_evt(e);
        end
        if ((|bus.task_go) || bus.commit || bus.overrun) begin
            check("pulse_excl", 64'($countones({bus.task_go, bus.commit, bus.overrun})), 64'd1);
            gi = 0;
            for (int i = N - 1; i >= 0; i--) if (bus.task_go[i]) gi = i;
            k = bus.commit ? K_CMT : (bus.overrun ? K_OVR : K_GO);
            d = (k == K_GO) ? 16'(gi) : bus.frame_cnt;
            act = mk_evt(cyc, k, d);
            check("busy_at_evt", 64'(bus.busy), 64'(k != K_OVR));
            if (exp_q.size() != 0 && int'(exp_q[0][49:18]) == cyc) begin
                e = exp_q.pop_front();
                check("event", 64'(act), 64'(e));
                handle_evt(e);
            end else begin
                check("unexpected_evt", 64'(act), 64'd0);
            end
        end
    endtask

    // Raster free-runs; done pulses come from the responder schedule.
    task automatic drive_defaults();
        logic [N-1:0] td;
        if (bus.xpix == 10'(H_TOTAL - 1)) begin
            bus.xpix = '0;
            bus.ypix = (bus.ypix == 10'(V_TOTAL - 1)) ? 10'd0 : bus.ypix + 10'd1;
        end else begin
            bus.xpix = bus.xpix + 10'd1;
        end
        td = '0;
        for (int i = 0; i < N; i++) td[i] = (done_at[i] == cyc);
        bus.task_done = td;
    endtask

    task automatic cycle();
        evaluate_inputs();
        @(posedge clk);
        #1;
        cyc++;
        monitor();
        drive_defaults();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic seek(input int x, input int y);
        bus.xpix = 10'(x);
        bus.ypix = 10'(y);
    endtask

    task automatic set_replies(input int d0, input int d1, input int d2);
        reply_dly[0] = d0;
        reply_dly[1] = d1;
        reply_dly[2] = d2;
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((sched_active || exp_q.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        check("seq_finished", 64'(sched_active), 64'd0);
        run(4);
        check("busy_idle", 64'(bus.busy), 64'd0);
        check("state_idle", 64'(state_dbg), 64'(ST_IDLE));
        check("frame_cnt", 64'(bus.frame_cnt), 64'(model_fc));
    endtask

    task automatic wait_go(input int i, input int budget);
        int n;
        n = 0;
        while (!go_seen[i] && n < budget) begin
            cycle();
            n++;
        end
        check("go_seen", 64'(go_seen[i]), 64'd1);
    endtask

    task automatic start_frame();
        for (int i = 0; i < N; i++) go_seen[i] = 1'b0;
        seek(H_TOTAL - 1, V_VISIBLE - 1);
        cycle();
    endtask

    task automatic check_reset_outputs();
        check("rst_task_go", 64'(bus.task_go), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_commit", 64'(bus.commit), 64'd0);
        check("rst_overrun", 64'(bus.overrun), 64'd0);
        check("rst_frame_cnt", 64'(bus.frame_cnt), 64'd0);
        check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        cyc = 0; n_checks = 0; n_errors = 0;
        model_fc = '0; sched_active = 1'b0; expect_timeout = 1'b0;
        cancel_dones();
        set_replies(5, 5, 5);
        rst = 1'b1;
        bus.xpix = '0; bus.ypix = '0; bus.pause = 1'b0; bus.task_done = '0;
        run(3);
        check_reset_outputs();
        rst = 1'b0;

        // Nominal frame, fixed 5-cycle replies.
        start_frame();
        run_until_idle(80);

        // Frames with random reply latencies.
        for (int f = 0; f < 3; f++) begin
            set_replies($urandom_range(1, 9), $urandom_range(1, 9), $urandom_range(1, 9));
            start_frame();
            run_until_idle(80);
        end

        // Pause held over the tick skips the frame; next frame runs.
        set_replies(5, 5, 5);
        bus.pause = 1'b1;
        start_frame();
        run(20);
        check("pause_busy", 64'(bus.busy), 64'd0);
        check("pause_frame_cnt", 64'(bus.frame_cnt), 64'(model_fc));
        bus.pause = 1'b0;
        start_frame();
        run_until_idle(80);

        // Stray done[2] while waiting on task 0 is ignored.
        set_replies(8, 5, 5);
        start_frame();
        wait_go(0, 10);
        cycle();
        bus.task_done[2] = 1'b1;
        run_until_idle(80);

        // Task 1 never replies: timeout overrun, then a normal frame.
        set_replies(5, -1, 5);
        expect_timeout = 1'b1;
        start_frame();
        run_until_idle(TIMEOUT + 100);
        expect_timeout = 1'b0;
        set_replies(5, 5, 5);
        start_frame();
        run_until_idle(80);

        // Task 2 stalls until blank end; a done[2] on the vend cycle loses.
        set_replies(5, 5, -1);
        start_frame();
        wait_go(2, 40);
        run(3);
        seek(H_TOTAL - 1, V_TOTAL - 1);
        bus.task_done[2] = 1'b1;
        run_until_idle(10);

        // Reset in the middle of waiting on task 0, then restart from go[0].
        set_replies(40, 5, 5);
        start_frame();
        wait_go(0, 10);
        run(3);
        rst = 1'b1;
        exp_q.delete();
        cancel_dones();
        sched_active = 1'b0;
        model_fc = '0;
        cycle();
        check_reset_outputs();
        rst = 1'b0;
        set_replies(5, 5, 5);
        start_frame();
        run_until_idle(80);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
